// File: rtl/pong_game_ctrl_if.sv
// rtl/pong_game_ctrl_if.sv - frame/control inputs and game-state outputs of the pong controller
interface pong_game_ctrl_if;
  logic        i_frameTick;
  logic        i_startBtn;
  logic        i_upL;
  logic        i_downL;
  logic        i_upR;
  logic        i_downR;
  logic [11:0] o_ballX;
  logic [11:0] o_ballY;
  logic [11:0] o_paddleLY;
  logic [11:0] o_paddleRY;
  logic [3:0]  o_scoreL;
  logic [3:0]  o_scoreR;
  logic [2:0]  o_gameState;
  logic        o_gameOver;

  modport master (
    output i_frameTick, i_startBtn, i_upL, i_downL, i_upR, i_downR,
    input  o_ballX, o_ballY, o_paddleLY, o_paddleRY, o_scoreL, o_scoreR, o_gameState, o_gameOver
  );

  modport slave (
    input  i_frameTick, i_startBtn, i_upL, i_downL, i_upR, i_downR,
    output o_ballX, o_ballY, o_paddleLY, o_paddleRY, o_scoreL, o_scoreR, o_gameState, o_gameOver
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game FSM: serve, ball/paddle physics, scoring
// Optional ball speed-up on paddle hits: define PONG_SPEEDUP_EN.
module pong_game_ctrl #(
  parameter int SCREEN_W     = 800,
  parameter int SCREEN_H     = 600,
  parameter int BALL_SIZE    = 10,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 80,
  parameter int PADDLE_XL    = 20,
  parameter int PADDLE_XR    = 770,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  pong_game_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2, S_POINT = 3'd3, S_GAMEOVER = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [11:0] C_BALL_X0 = 12'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [11:0] C_BALL_Y0 = 12'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [11:0] C_PAD0    = 12'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [3:0]  C_WIN     = 4'(WIN_SCORE);
  localparam logic signed [12:0] C_X_MAX   = 13'(SCREEN_W - BALL_SIZE);
  localparam logic signed [12:0] C_Y_MAX   = 13'(SCREEN_H - BALL_SIZE);
  localparam logic signed [12:0] C_PAD_MAX = 13'(SCREEN_H - PADDLE_H);
  localparam logic signed [12:0] C_L_BACK  = 13'(PADDLE_XL);
  localparam logic signed [12:0] C_L_FACE  = 13'(PADDLE_XL + PADDLE_W);
  localparam logic signed [12:0] C_R_FACE  = 13'(PADDLE_XR);
  localparam logic signed [12:0] C_R_BACK  = 13'(PADDLE_XR + PADDLE_W);
  localparam logic signed [12:0] C_R_HIT   = 13'(PADDLE_XR - BALL_SIZE);
  localparam logic signed [12:0] C_BS      = 13'(BALL_SIZE);
  localparam logic signed [12:0] C_PH      = 13'(PADDLE_H);
  localparam logic signed [12:0] C_STEP    = 13'(PADDLE_STEP);
  localparam logic signed [12:0] C_SPEED   = 13'(BALL_SPEED);

  state_t             r_state;
  logic               r_start_q;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic [11:0]        r_ball_x, r_ball_y, r_pad_l, r_pad_r;
  logic               r_vx_neg, r_vy_neg;
  logic [3:0]         r_score_l, r_score_r;
  logic               r_game_over;
  logic               r_left_conceded;

  logic               w_start_edge, w_point_won, w_enter_serve;
  logic signed [12:0] w_vx_mag, w_vx, w_vy, w_pos_x, w_pos_y, w_next_x, w_next_y, w_pl, w_pr;
  logic               w_hit_l, w_hit_r, w_miss_l, w_miss_r;
  logic [11:0]        w_ball_x_nxt, w_ball_y_nxt;
  logic               w_vy_neg_nxt;

  function automatic logic [11:0] f_paddle(input logic [11:0] p, input logic up, input logic dn);
    logic signed [12:0] v;
    v = $signed({1'b0, p});
    if (up && !dn)      v = (v - C_STEP <= 13'sd0) ? 13'sd0 : v - C_STEP;
    else if (dn && !up) v = (v + C_STEP >= C_PAD_MAX) ? C_PAD_MAX : v + C_STEP;
    return v[11:0];
  endfunction

  assign w_start_edge  = bus.i_startBtn & ~r_start_q;
  assign w_point_won   = r_left_conceded ? (r_score_r >= C_WIN) : (r_score_l >= C_WIN);
  assign w_enter_serve = (((r_state == S_IDLE) || (r_state == S_GAMEOVER)) && w_start_edge)
                       || ((r_state == S_POINT) && !w_point_won);

`ifdef PONG_SPEEDUP_EN
  logic [2:0] r_vx_mag;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                r_vx_mag <= 3'(BALL_SPEED);
    else if (w_enter_serve)   r_vx_mag <= 3'(BALL_SPEED);
    else if ((r_state == S_PLAY) && bus.i_frameTick && (w_hit_l || w_hit_r) && (r_vx_mag < 3'd6))
      r_vx_mag <= r_vx_mag + 3'd1;
  end
  assign w_vx_mag = $signed({10'd0, r_vx_mag});
`else
  assign w_vx_mag = C_SPEED;
`endif

  assign w_vx     = r_vx_neg ? -w_vx_mag : w_vx_mag;
  assign w_vy     = r_vy_neg ? -C_SPEED : C_SPEED;
  assign w_pos_x  = $signed({1'b0, r_ball_x});
  assign w_pos_y  = $signed({1'b0, r_ball_y});
  assign w_pl     = $signed({1'b0, r_pad_l});
  assign w_pr     = $signed({1'b0, r_pad_r});
  assign w_next_x = w_pos_x + w_vx;
  assign w_next_y = w_pos_y + w_vy;

  // Paddle overlap uses the pre-move ball Y; horizontal test uses the next X.
  assign w_hit_l  = r_vx_neg && (w_next_x <= C_L_FACE) && (w_next_x + C_BS > C_L_BACK)
                  && (w_pos_y + C_BS > w_pl) && (w_pos_y < w_pl + C_PH);
  assign w_hit_r  = !r_vx_neg && (w_next_x + C_BS >= C_R_FACE) && (w_next_x < C_R_BACK)
                  && (w_pos_y + C_BS > w_pr) && (w_pos_y < w_pr + C_PH);
  assign w_miss_l = !w_hit_l && !w_hit_r && (w_next_x <= 13'sd0);
  assign w_miss_r = !w_hit_l && !w_hit_r && (w_next_x >= C_X_MAX);

  always_comb begin
    w_ball_x_nxt = w_next_x[11:0];
    if (w_hit_l)       w_ball_x_nxt = C_L_FACE[11:0];
    else if (w_hit_r)  w_ball_x_nxt = C_R_HIT[11:0];
    else if (w_miss_l) w_ball_x_nxt = '0;
    else if (w_miss_r) w_ball_x_nxt = C_X_MAX[11:0];
    w_ball_y_nxt = w_next_y[11:0];
    w_vy_neg_nxt = r_vy_neg;
    if (w_next_y <= 13'sd0) begin
      w_ball_y_nxt = '0;
      w_vy_neg_nxt = 1'b0;
    end else if (w_next_y >= C_Y_MAX) begin
      w_ball_y_nxt = C_Y_MAX[11:0];
      w_vy_neg_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_start_q       <= 1'b0;
      r_frame_cnt     <= '0;
      r_ball_x        <= C_BALL_X0;
      r_ball_y        <= C_BALL_Y0;
      r_vx_neg        <= 1'b1;
      r_vy_neg        <= 1'b0;
      r_pad_l         <= C_PAD0;
      r_pad_r         <= C_PAD0;
      r_score_l       <= '0;
      r_score_r       <= '0;
      r_game_over     <= 1'b0;
      r_left_conceded <= 1'b1;
    end else begin
      r_start_q <= bus.i_startBtn;
      case (r_state)
        S_IDLE: if (w_start_edge) begin
          r_state         <= S_SERVE;
          r_left_conceded <= 1'b1;
        end
        S_SERVE: if (bus.i_frameTick) begin
          r_pad_l     <= f_paddle(r_pad_l, bus.i_upL, bus.i_downL);
          r_pad_r     <= f_paddle(r_pad_r, bus.i_upR, bus.i_downR);
          r_frame_cnt <= r_frame_cnt + CNT_W'(1);
          if (r_frame_cnt == CNT_W'(SERVE_FRAMES - 1)) r_state <= S_PLAY;
        end
        S_PLAY: if (bus.i_frameTick) begin
          r_pad_l  <= f_paddle(r_pad_l, bus.i_upL, bus.i_downL);
          r_pad_r  <= f_paddle(r_pad_r, bus.i_upR, bus.i_downR);
          r_ball_x <= w_ball_x_nxt;
          r_ball_y <= w_ball_y_nxt;
          r_vy_neg <= w_vy_neg_nxt;
          if (w_hit_l || w_hit_r) r_vx_neg <= ~r_vx_neg;
          if (w_miss_l || w_miss_r) begin
            r_state         <= S_POINT;
            r_left_conceded <= w_miss_l;
            if (w_miss_l && (r_score_r < C_WIN)) r_score_r <= r_score_r + 4'd1;
            if (w_miss_r && (r_score_l < C_WIN)) r_score_l <= r_score_l + 4'd1;
          end
        end
        S_POINT: if (w_point_won) begin
          r_state     <= S_GAMEOVER;
          r_game_over <= 1'b1;
        end else begin
          r_state <= S_SERVE;
        end
        S_GAMEOVER: if (w_start_edge) begin
          r_state         <= S_SERVE;
          r_game_over     <= 1'b0;
          r_score_l       <= '0;
          r_score_r       <= '0;
          r_left_conceded <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
      // Serve always aims at whoever conceded; a fresh start counts as the left player.
      if (w_enter_serve) begin
        r_ball_x    <= C_BALL_X0;
        r_ball_y    <= C_BALL_Y0;
        r_vx_neg    <= (r_state == S_POINT) ? r_left_conceded : 1'b1;
        r_vy_neg    <= 1'b0;
        r_frame_cnt <= '0;
      end
    end
  end

  assign bus.o_ballX     = r_ball_x;
  assign bus.o_ballY     = r_ball_y;
  assign bus.o_paddleLY  = r_pad_l;
  assign bus.o_paddleRY  = r_pad_r;
  assign bus.o_scoreL    = r_score_l;
  assign bus.o_scoreR    = r_score_r;
  assign bus.o_gameState = r_state;
  assign bus.o_gameOver  = r_game_over;
endmodule
